// File: rtl/sign_narrow_pkg.sv
// Shared constants for the 32->16 signed narrowing stage: widths, saturation
// limits, mode encoding and buffer occupancy states.
package sign_narrow_pkg;

   localparam int IN_W_DEF  = 32;
   localparam int OUT_W_DEF = 16;

   localparam logic [15:0] SAT_MAX = 16'h7FFF;
   localparam logic [15:0] SAT_MIN = 16'h8000;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/sign_narrow_core.sv
// Combinational fit test plus wrap/saturate narrowing of a signed value.
module sign_narrow_core
   import sign_narrow_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_sat,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf
);

   localparam logic [OUT_W-1:0] LP_SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] LP_SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   // The value fits when everything from the new sign bit upward is a copy of it.
   logic [IN_W-OUT_W:0] w_upper;
   logic                w_fits;

   assign w_upper = in_data[IN_W-1:OUT_W-1];
   assign w_fits  = (&w_upper) | ~(|w_upper);

   always_comb begin
      out_data = in_data[OUT_W-1:0];
      out_ovf  = ~w_fits;
      if ((in_sat == MODE_SAT) && !w_fits) begin
         out_data = in_data[IN_W-1] ? LP_SAT_MIN : LP_SAT_MAX;
      end else begin
         out_data = in_data[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/sign_narrow.sv
// Narrowing stage with valid/ready handshake and a 2-entry skid buffer.
// Optional overflow event counter enabled by SIGN_NARROW_STATS_EN.
module sign_narrow
   import sign_narrow_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             clr_count
);

   logic [1:0]       r_state;
   logic             r_valid;
   logic [OUT_W-1:0] r_head_data;
   logic             r_head_ovf;
   logic [OUT_W-1:0] r_skid_data;
   logic             r_skid_ovf;

   logic [1:0]       w_state_nxt;
   logic [OUT_W-1:0] w_new_data;
   logic             w_new_ovf;
   logic             w_accept;
   logic             w_retire;
   logic             w_head_ld_new;
   logic             w_head_ld_skid;
   logic             w_skid_ld;

   sign_narrow_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .in_data  (in_data),
      .in_sat   (in_sat),
      .out_data (w_new_data),
      .out_ovf  (w_new_ovf)
   );

   assign in_ready = (r_state != ST_TWO) && !reset;
   assign w_accept = in_valid && in_ready;
   assign w_retire = r_valid && out_ready;

   // Occupancy FSM: decide the next state and which register loads what.
   always_comb begin
      w_state_nxt    = r_state;
      w_head_ld_new  = 1'b0;
      w_head_ld_skid = 1'b0;
      w_skid_ld      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt   = ST_ONE;
               w_head_ld_new = 1'b1;
            end else begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (w_accept && w_retire) begin
               w_state_nxt   = ST_ONE;
               w_head_ld_new = 1'b1;
            end else if (w_accept) begin
               w_state_nxt = ST_TWO;
               w_skid_ld   = 1'b1;
            end else if (w_retire) begin
               w_state_nxt = ST_EMPTY;
            end else begin
               w_state_nxt = ST_ONE;
            end
         end
         ST_TWO: begin
            if (w_retire) begin
               w_state_nxt    = ST_ONE;
               w_head_ld_skid = 1'b1;
            end else begin
               w_state_nxt = ST_TWO;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   // State, head and skid registers; outputs are taken directly from the head.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_EMPTY;
         r_valid     <= 1'b0;
         r_head_data <= {OUT_W{1'b0}};
         r_head_ovf  <= 1'b0;
         r_skid_data <= {OUT_W{1'b0}};
         r_skid_ovf  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= (w_state_nxt != ST_EMPTY);
         if (w_head_ld_new) begin
            r_head_data <= w_new_data;
            r_head_ovf  <= w_new_ovf;
         end else if (w_head_ld_skid) begin
            r_head_data <= r_skid_data;
            r_head_ovf  <= r_skid_ovf;
         end
         if (w_skid_ld) begin
            r_skid_data <= w_new_data;
            r_skid_ovf  <= w_new_ovf;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_head_data;
   assign out_ovf   = r_head_ovf;

`ifdef SIGN_NARROW_STATS_EN
   logic [CNT_W-1:0] r_ovf_count;

   // Saturating count of accepted overflowing values; clear beats increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf_count <= {CNT_W{1'b0}};
      end else if (clr_count) begin
         r_ovf_count <= {CNT_W{1'b0}};
      end else if (w_accept && w_new_ovf && (r_ovf_count != {CNT_W{1'b1}})) begin
         r_ovf_count <= r_ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign ovf_count = r_ovf_count;
`else
   logic w_unused_clr;

   assign w_unused_clr = clr_count;
   assign ovf_count    = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/sign_narrow.md
Name: sign_narrow

Overview:
- Inverse of the 16->32 immediate/halfword sign extension in the datapath.
- Narrows a 32-bit two's-complement value to 16 bits for the store-halfword path and 16-bit result writeback.
- Flags values not representable as a sign-extended 16-bit quantity; per transaction, either wraps or saturates them.
- Sits between the ALU result stage and the memory write-data stage behind a valid/ready handshake, with a 2-entry skid buffer so back-pressure never drops data.

Parameters:
- IN_W, 32, input data width.
- OUT_W, 16, output data width; must be less than IN_W.
- CNT_W, 8, width of the overflow event counter (used only when SIGN_NARROW_STATS_EN is defined).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a value.
- in_ready  output  1  block can accept a value this cycle.
- in_data  input  IN_W  32-bit two's-complement value.
- in_sat  input  1  per-transaction mode: 0 = wrap (truncate), 1 = saturate.
- out_valid  output  1  narrowed value available.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  OUT_W  narrowed value.
- out_ovf  output  1  value did not fit in OUT_W signed bits.
- ovf_count  output  CNT_W  overflow events, saturating (STATS_EN only).
- clr_count  input  1  synchronous counter clear (STATS_EN only).

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: out_valid=0, out_data=0, out_ovf=0, ovf_count=0, buffer occupancy=0. in_ready=0 while reset is high and 1 in the first cycle after.
- Fit test: fits = in_data[31:15] all 0 or all 1.
- Wrap mode (in_sat=0): data = in_data[15:0]; ovf = !fits.
- Saturate mode (in_sat=1), value fits: data = in_data[15:0], ovf=0.
- Saturate mode, value does not fit: data = 16'h8000 if in_data[31]=1, else 16'h7FFF; ovf=1.
- Accept: a value is accepted when in_valid && in_ready. Data and ovf are computed at acceptance and stored as a 17-bit entry.
- Retire: an entry leaves when out_valid && out_ready.
- Buffer FSM, state = occupancy:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1. Accept only -> TWO. Retire only -> EMPTY. Accept and retire together -> ONE; the new entry becomes head.
  - TWO: out_valid=1, in_ready=0. Retire -> ONE; the skid entry moves to head.
- Latency: 1 cycle. A value accepted in cycle N is on out_* in cycle N+1 when the buffer was EMPTY, or ONE with a retire in cycle N.
- Ordering: strictly FIFO.
- Registered outputs: out_data, out_ovf and out_valid come straight from the head register, with no combinational path from in_*. in_ready depends only on state, with no combinational path from out_ready.
- Hold rule: while out_valid=1 && out_ready=0, out_data and out_ovf stay stable.
- Reset mid-operation: buffered entries are discarded. Outputs return to reset values at the next edge.

Optional Feature:
- Macro: SIGN_NARROW_STATS_EN.
- Defined:
  - ovf_count increments by 1 on each accepted value with ovf=1, and saturates at 2^CNT_W-1 (255).
  - clr_count=1 forces 0 at the next edge. Clear wins over a simultaneous increment.
  - Reset clears the counter.
- Undefined:
  - ovf_count is driven constant 0 and clr_count is ignored.
  - No counter flops are synthesized. The port list is unchanged.

Decomposition:
- Package sign_narrow_pkg holds:
  - IN_W/OUT_W defaults.
  - SAT_MAX=16'h7FFF and SAT_MIN=16'h8000.
  - Mode constants MODE_WRAP=0 and MODE_SAT=1.
  - The 2-bit occupancy state encoding: EMPTY=0, ONE=1, TWO=2.
- One sub-module, sign_narrow_core: purely combinational fit test plus wrap/saturate, producing {ovf, data}.
- The top holds the FSM, the head and skid registers, and the counter.

Test Plan:
- Fits, wrap mode: in_data=32'hFFFF_8000, in_sat=0, out_ready=1 -> next cycle out_data=16'h8000, out_ovf=0.
- Overflow, wrap vs saturate:
  - in_data=32'h0001_2345, in_sat=0 -> out_data=16'h2345, ovf=1.
  - Same value with in_sat=1 -> 16'h7FFF, ovf=1.
  - in_data=32'h8000_0000, in_sat=1 -> 16'h8000, ovf=1.
- Back-pressure: out_ready=0; send A=32'h10, B=32'h20 -> in_ready=0 after B is accepted, out_data holds 16'h0010. Raise out_ready -> outputs 16'h0010 then 16'h0020 on consecutive cycles, then out_valid=0.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles, values 0..7 -> one output per cycle, in order, in_ready stays 1.
- Reset mid-flight: buffer in state TWO, assert reset for 1 cycle -> out_valid=0, earlier entries never appear; the next accepted value appears 1 cycle later.
- STATS_EN: 300 accepted overflowing values -> ovf_count=255. Assert clr_count in the same cycle as an overflowing accept -> ovf_count=0.
